// File: rtl/axis_img_pkg.sv
// ============================================================================
// axis_img_pkg : shared types and width helpers for the image stream stages
// Revision     : 1.0
// ============================================================================
`default_nettype none

package axis_img_pkg;

  localparam int AXIS_TDATA_W = 32;

  typedef struct packed {
    logic [AXIS_TDATA_W-1:0] tdata;
    logic                    tlast;
    logic                    tuser;
  } axis_beat_t;

  typedef enum logic [0:0] {
    ST_SOF    = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
// axis_skid_buffer : 2-entry AXI-Stream skid buffer with registered ready
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axis_skid_buffer
  import axis_img_pkg::*;
#(
  parameter type T = axis_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid_i,
  output logic s_ready_o,
  input  T     s_data_i,
  output logic m_valid_o,
  input  logic m_ready_i,
  output T     m_data_o
);

  logic [1:0] count_q, count_d;
  T           head_q, head_d;
  T           skid_q, skid_d;
  logic       ready_q;
  logic       valid_q;
  logic       in_fire;
  logic       out_fire;

  assign in_fire  = s_valid_i & ready_q;
  assign out_fire = valid_q & m_ready_i;

  // head_q is the presented beat; skid_q only holds the one beat absorbed after a stall
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case ({in_fire, out_fire})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = s_data_i;
          count_d = 2'd1;
        end else begin
          skid_d  = s_data_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d  = skid_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'b11: begin
        head_d = s_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= (count_d != 2'd2);
      valid_q <= (count_d != 2'd0);
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = valid_q;
  assign m_data_o  = head_q;

endmodule

`default_nettype wire

// File: rtl/axis_line_framer.sv
// ============================================================================
// axis_line_framer : retags a frame-TLAST pixel stream with line TLAST and SOF
//                    TUSER, checking geometry. AXIS_LINE_FRAMER_STATS_EN adds
//                    the 16-bit completed-frame counter.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axis_line_framer
  import axis_img_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  clr_err,
  output logic                  err_early_last,
  output logic                  err_missing_last,
  output logic [15:0]           frame_cnt
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;
  } beat_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  frame_state_e     state_q, state_d;
  logic             early_q, early_d;
  logic             missing_q, missing_d;

  logic  accept;
  logic  at_last_col;
  logic  at_frame_end;
  logic  frame_end;
  beat_t in_beat;
  beat_t out_beat;

  assign accept       = s_axis_tvalid & s_axis_tready;
  assign at_last_col  = (col_q == COL_LAST);
  assign at_frame_end = at_last_col && (row_q == ROW_LAST);
  assign frame_end    = s_axis_tlast | at_frame_end;

  assign in_beat.tdata = s_axis_tdata;
  assign in_beat.tlast = at_last_col | s_axis_tlast;
  assign in_beat.tuser = (state_q == ST_SOF) && (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    state_d   = state_q;
    early_d   = early_q & ~clr_err;
    missing_d = missing_q & ~clr_err;
    if (accept) begin
      if (s_axis_tlast && !at_frame_end) early_d = 1'b1;
      if (!s_axis_tlast && at_frame_end) missing_d = 1'b1;
      // Any frame end, expected or not, resynchronises to the top-left pixel
      if (frame_end) begin
        col_d   = '0;
        row_d   = '0;
        state_d = ST_SOF;
      end else begin
        state_d = ST_ACTIVE;
        if (at_last_col) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      col_q     <= '0;
      row_q     <= '0;
      state_q   <= ST_SOF;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      state_q   <= state_d;
      early_q   <= early_d;
      missing_q <= missing_d;
    end
  end

`ifdef AXIS_LINE_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = (accept && frame_end) ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) frame_cnt_q <= 16'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  axis_skid_buffer #(
    .T (beat_t)
  ) u_skid (
    .clk       (aclk),
    .rst       (areset),
    .s_valid_i (s_axis_tvalid),
    .s_ready_o (s_axis_tready),
    .s_data_i  (in_beat),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (out_beat)
  );

  assign m_axis_tdata     = out_beat.tdata;
  assign m_axis_tlast     = out_beat.tlast;
  assign m_axis_tuser     = out_beat.tuser;
  assign err_early_last   = early_q;
  assign err_missing_last = missing_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_line_framer.sv
// ============================================================================
// tb_axis_line_framer : randomized self-checking bench for axis_line_framer
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_axis_line_framer;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FRAME_LEN = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          m_user;
  logic          clr = 1'b0;
  logic          err_early;
  logic          err_miss;
  logic [15:0]   fcnt;

  always #5 clk = ~clk;

  axis_line_framer #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .aclk             (clk),
    .areset           (rst),
    .s_axis_tdata     (s_data),
    .s_axis_tvalid    (s_valid),
    .s_axis_tready    (s_ready),
    .s_axis_tlast     (s_last),
    .m_axis_tdata     (m_data),
    .m_axis_tvalid    (m_valid),
    .m_axis_tready    (m_ready),
    .m_axis_tlast     (m_last),
    .m_axis_tuser     (m_user),
    .clr_err          (clr),
    .err_early_last   (err_early),
    .err_missing_last (err_miss),
    .frame_cnt        (fcnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: position within the frame, counted 0..W*H-1
  stim_t stim_q[$];
  beat_t exp_q[$];
  int    pos = 0;
  bit    m_early = 0;
  bit    m_miss = 0;
  int    m_frames = 0;
  bit    ready_seen = 0;
  bit    stall_q = 0;
  logic [63:0] stall_b = '0;

  function automatic logic [15:0] exp_fcnt();
`ifdef AXIS_LINE_FRAMER_STATS_EN
    return 16'(m_frames);
`else
    return 16'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pos = 0; m_early = 0; m_miss = 0; m_frames = 0;
      ready_seen = 0; stall_q = 0;
    end else begin
      if (ready_seen) check_eq("ready_vs_fill", s_ready, exp_q.size() != 2);
      check_eq("valid_vs_fill", m_valid, exp_q.size() != 0);
      if (s_ready) ready_seen = 1;
      if (stall_q) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_beat", {30'd0, m_data, m_last, m_user}, stall_b);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check_eq("out_beat", {30'd0, m_data, m_last, m_user}, {30'd0, e});
        end
      end
      stall_q = m_valid && !m_ready;
      stall_b = {30'd0, m_data, m_last, m_user};
      if (clr) begin m_early = 0; m_miss = 0; end
      if (s_valid && s_ready) begin
        beat_t b;
        b.d = s_data;
        b.u = (pos == 0);
        b.l = s_last || (pos % W == W - 1);
        if (s_last && pos != FRAME_LEN - 1) m_early = 1;
        if (!s_last && pos == FRAME_LEN - 1) m_miss = 1;
        if (s_last || pos == FRAME_LEN - 1) begin
          pos = 0;
          m_frames = (m_frames + 1) % 65536;
        end else pos++;
        exp_q.push_back(b);
      end
    end
  end

  task automatic push_seq(input int start, input int n, input int last_at);
    for (int i = 0; i < n; i++) stim_q.push_back({DW'(start + i), (i + 1 == last_at)});
  endtask

  task automatic run(input int vpct, input int rpct, input int maxc, input bit must_finish);
    int cyc = 0;
    bit fire;
    while ((stim_q.size() > 0 || s_valid) && cyc < maxc) begin
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) s_valid = 1'b0;
      if (!s_valid && stim_q.size() > 0 && $urandom_range(99) < vpct) begin
        stim_t st;
        st = stim_q.pop_front();
        s_data = st.d; s_last = st.l; s_valid = 1'b1;
      end
      m_ready = ($urandom_range(99) < rpct);
    end
    if (must_finish) check_eq("stim_timeout", cyc >= maxc, 0);
  endtask

  task automatic drain(input int rpct);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(99) < rpct) || (cyc > 100);
      cyc++;
    end
    @(posedge clk); #1;
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_early"}, err_early, m_early);
    check_eq({tag, "_miss"}, err_miss, m_miss);
    check_eq({tag, "_fcnt"}, fcnt, exp_fcnt());
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    check_eq("clr_early", err_early, 0);
    check_eq("clr_miss", err_miss, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, s_ready, 0);
    check_eq({tag, "_valid"}, m_valid, 0);
    check_eq({tag, "_data"}, m_data, 0);
    check_eq({tag, "_tlast"}, m_last, 0);
    check_eq({tag, "_tuser"}, m_user, 0);
    check_eq({tag, "_errs"}, {err_early, err_miss}, 0);
    check_eq({tag, "_fcnt"}, fcnt, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    #1 check_eq("ready_before_edge", s_ready, 0);
    @(posedge clk); #1 check_eq("ready_after_edge", s_ready, 1);

    // Clean frame, no back-pressure
    push_seq(1, 8, 8); run(100, 100, 100, 1); drain(100); check_status("clean");
    check_eq("clean_fcnt_abs", fcnt, exp_fcnt());

    // Same frame under random stalls
    push_seq(1, 8, 8); run(70, 50, 300, 1); drain(50); check_status("stall");

    // Early TLAST then a clean frame
    push_seq(1, 6, 6); push_seq(1, 8, 8); run(80, 60, 300, 1); drain(60); check_status("early");
    check_eq("early_flag_set", err_early, 1);
    pulse_clr();

    // Missing TLAST then a clean frame
    push_seq(1, 8, 0); push_seq(9, 8, 8); run(80, 60, 300, 1); drain(60); check_status("missing");
    check_eq("missing_flag_set", err_miss, 1);
    pulse_clr();

    // Random-length frames with random data and TLAST placement
    for (int k = 0; k < 12; k++) begin
      int len;
      bit lst;
      len = $urandom_range(12, 2);
      lst = ($urandom_range(3) != 0);
      for (int i = 0; i < len; i++) stim_q.push_back({DW'($urandom), (lst && i == len - 1)});
    end
    run(75, 65, 2000, 1); drain(65); check_status("random");
    pulse_clr();

    // Reset while beats sit in the skid buffer
    push_seq(1, 8, 8); run(100, 0, 6, 0);
    stim_q.delete();
    s_valid = 1'b0; s_last = 1'b0;
    rst = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    push_seq(1, 8, 8); run(90, 70, 300, 1); drain(70); check_status("post_reset");
    check_eq("post_reset_errs", {err_early, err_miss}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/axis_line_framer.md
Name: axis_line_framer

Overview:
- Downstream neighbour of the image AXI-Stream IP (myip_v1_0). It consumes the IP's m00 pixel stream, where TLAST marks only the frame end.
- It re-emits the stream with TLAST on every line end and TUSER on the first pixel of each frame (start of frame), which is what the video/DMA sink expects.
- It checks the frame geometry against the incoming TLAST and flags mismatches.
- It decouples back-pressure through a 2-entry skid buffer, so s_axis_tready is a registered signal.

Parameters:
- DATA_WIDTH, 32, TDATA width in bits.
- IMG_WIDTH, 640, pixels (beats) per line; must be ≥2.
- IMG_HEIGHT, 480, lines per frame; must be ≥1.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready (registered).
- s_axis_tlast  in  1  input end of frame.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of line.
- m_axis_tuser  out  1  output start of frame.
- clr_err  in  1  one-cycle pulse that clears the sticky error flags.
- err_early_last  out  1  sticky: input TLAST arrived before the frame end.
- err_missing_last  out  1  sticky: frame end reached without input TLAST.
- frame_cnt  out  16  completed-frame count (see Optional Feature).

Behaviour:
- Clock and reset: one clock, aclk; reset is asynchronous and active-high, on areset.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, both error flags=0, frame_cnt=0, col=0, row=0, skid buffer empty.
  - s_axis_tready rises on the first clock edge after areset deasserts.
- Input acceptance: an input beat is accepted on a clock edge when s_axis_tvalid & s_axis_tready.
  - Accepted beats are tagged (tlast_out, tuser_out) and written to the skid buffer.
  - s_axis_tready = buffer not full, registered.
- Skid buffer: 2 entries.
  - Output is valid the cycle after acceptance when the buffer was empty, so latency is 1 cycle.
  - Sustains 1 beat/cycle when m_axis_tready is held high.
  - When m_axis_tready drops, at most one further beat is absorbed; then s_axis_tready falls.
- AXI-Stream output rules:
  - m_axis_tvalid never drops without a handshake.
  - m_axis_tdata, tlast and tuser are stable while tvalid=1 and tready=0.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1, on $clog2 widths.
  - Both advance only on an accepted input beat.
  - col wraps to 0 at IMG_WIDTH-1, which increments row.
  - row wraps to 0 at the last beat of the frame.
- Tagging:
  - tuser_out = (col==0 && row==0).
  - tlast_out = (col==IMG_WIDTH-1) OR input TLAST.
- FSM, two states:
  - SOF: waiting for the first beat of a frame.
  - ACTIVE: inside a frame.
  - SOF→ACTIVE on an accepted beat unless that beat also ends the frame.
  - ACTIVE→SOF on the frame-end beat, either expected or early.
- Frame end, expected: beat at col=W-1, row=H-1 with input TLAST=1.
  - Counters go to 0; frame_cnt increments.
- Early TLAST: input TLAST=1 at any other position.
  - Set err_early_last.
  - Output that beat with tlast_out=1.
  - Force col=row=0 (resync); frame_cnt increments.
- Missing TLAST: beat at col=W-1, row=H-1 with input TLAST=0.
  - Set err_missing_last.
  - Counters still wrap to 0 (forced frame boundary); frame_cnt increments.
- Sticky errors:
  - Cleared by clr_err.
  - If clr_err and a new error occur in the same cycle, the error wins (flag stays 1).
- Reset mid-frame: counters, buffer and FSM are cleared immediately. The next accepted beat is treated as SOF, with tuser=1.

Optional Feature:
- Macro: AXIS_LINE_FRAMER_STATS_EN.
- Defined: frame_cnt is a 16-bit counter that increments on every frame end (expected, early, or forced) and wraps from 0xFFFF to 0.
- Undefined: no counter register; frame_cnt is tied to 0. The port is always present.

Decomposition:
- Package axis_img_pkg holds:
  - typedef axis_beat_t (tdata, tlast, tuser) for the buffer entry;
  - localparam helpers for the counter widths;
  - typedef enum for the FSM states {ST_SOF, ST_ACTIVE}.
- Sub-module axis_skid_buffer: 2-entry, parameterised on the payload type/width, reusable by other stages.
- Counters, FSM and tagging stay in axis_line_framer.

Test Plan (bench overrides IMG_WIDTH=4, IMG_HEIGHT=2):
- Send beats 1..8 with TLAST on 8, m_axis_tready=1 → output 1..8 with tuser on 1, tlast on 4 and 8; no errors; frame_cnt=1 (with macro).
- Same frame with random m_axis_tready (50%) → identical ordered output 1..8; no data held under stall changes; s_axis_tready low only after 2 pending beats.
- Send beats 1..6 with TLAST on 6, then 1..8 with TLAST on 8 → err_early_last=1; beat 6 out with tlast=1; next beat 1 has tuser=1; frame_cnt=2.
- Send beats 1..8 with no TLAST, then 9..16 with TLAST on 16 → err_missing_last=1; tuser on 1 and 9; clr_err pulse → flag returns to 0.
- Assert areset after beat 3 of a frame, release it, then send 1..8 with TLAST on 8 → all outputs 0 during reset; afterwards output 1..8 with tuser on 1; no errors.
- Without AXIS_LINE_FRAMER_STATS_EN → frame_cnt stays 0 across the scenarios above.
